// File: rtl/pipeline_ctrl_unit.sv
// Central stall/flush controller: merges stage pause requests, commit-time redirects and
// execute mispredicts into pause/flush/redirect controls, with post-redirect hold and IDLE wait.
module pipeline_ctrl_unit #(
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           pause_req,
    input  logic                 excp_commit,
    input  logic [31:0]          excp_target,
    input  logic                 ertn_commit,
    input  logic [31:0]          era,
    input  logic                 idle_commit,
    input  logic [31:0]          idle_pc,
    input  logic                 int_pending,
    input  logic                 bp_flush,
    input  logic [31:0]          bp_target,
    output logic [4:0]           pause,
    output logic [5:0]           flush,
    output logic                 redirect_valid,
    output logic [31:0]          new_pc,
    output logic                 in_idle,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count
);

    localparam int HW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES);

    // Bit positions inside pause: {buffer, decoder, dispatch, execute, mem}
    localparam int P_BUF = 4;
    localparam int P_EXE = 1;

    typedef enum logic {
        RUN  = 1'b0,
        IDLE = 1'b1
    } state_t;

    state_t         state, state_nx;
    logic [HW-1:0]  hold_cnt, hold_nx;
    logic [4:0]     merged;

    // A stage stalls whenever it or any stage downstream of it stalls.
    always_comb begin
        merged[0] = pause_req[0];
        for (int k = 1; k < 5; k++) begin
            merged[k] = merged[k-1] | pause_req[k];
        end
    end

    // NOTE: every output of this block is given a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        pause          = '0;
        flush          = '0;
        redirect_valid = 1'b0;
        new_pc         = '0;
        state_nx       = state;
        hold_nx        = (hold_cnt != '0) ? hold_cnt - HW'(1) : hold_cnt;

        if (excp_commit) begin
            flush          = 6'b111111;
            new_pc         = excp_target;
            redirect_valid = 1'b1;
            state_nx       = RUN;
        end else if (ertn_commit) begin
            flush          = 6'b111111;
            new_pc         = era;
            redirect_valid = 1'b1;
            state_nx       = RUN;
        end else if (idle_commit) begin
            flush          = 6'b111110;
            new_pc         = idle_pc + 32'd4;
            redirect_valid = 1'b1;
            state_nx       = IDLE;
        end else begin
            pause = merged;
            if (hold_cnt != '0) begin
                pause[P_BUF] = 1'b1;
            end
            if (state == IDLE) begin
                // A pending interrupt releases the front end in the same cycle.
                if (int_pending) begin
                    state_nx = RUN;
                end else begin
                    pause[4:2] = 3'b111;
                end
            end
            // A paused execute stage holds its mispredict and re-asserts it later.
            if (bp_flush && !pause[P_EXE]) begin
                flush          = 6'b111000;
                new_pc         = bp_target;
                redirect_valid = 1'b1;
            end
        end

        if (redirect_valid) begin
            hold_nx = HOLD_INIT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            hold_cnt     <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;
            if ((pause != '0) && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (redirect_valid && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

    assign in_idle = (state == IDLE);

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Self-checking bench for pipeline_ctrl_unit: table-driven combinational vectors plus
// hand-written sequences for hold, IDLE, counters and asynchronous reset.
module tb_pipeline_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  pause_req;
    logic        excp_commit;
    logic [31:0] excp_target;
    logic        ertn_commit;
    logic [31:0] era;
    logic        idle_commit;
    logic [31:0] idle_pc;
    logic        int_pending;
    logic        bp_flush;
    logic [31:0] bp_target;
    logic [4:0]  pause;
    logic [5:0]  flush;
    logic        redirect_valid;
    logic [31:0] new_pc;
    logic        in_idle;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    int checks = 0;
    int errors = 0;

    pipeline_ctrl_unit #(.HOLD_CYCLES(2), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .pause_req(pause_req),
        .excp_commit(excp_commit), .excp_target(excp_target),
        .ertn_commit(ertn_commit), .era(era),
        .idle_commit(idle_commit), .idle_pc(idle_pc),
        .int_pending(int_pending), .bp_flush(bp_flush), .bp_target(bp_target),
        .pause(pause), .flush(flush), .redirect_valid(redirect_valid), .new_pc(new_pc),
        .in_idle(in_idle), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  req;
        logic        excp;
        logic        ertn;
        logic        bp;
        logic [31:0] tgt_excp;
        logic [31:0] tgt_era;
        logic [31:0] tgt_bp;
        logic [4:0]  exp_pause;
        logic [5:0]  exp_flush;
        logic        exp_redir;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        pause_req   = '0;
        excp_commit = 1'b0;
        excp_target = '0;
        ertn_commit = 1'b0;
        era         = '0;
        idle_commit = 1'b0;
        idle_pc     = '0;
        int_pending = 1'b0;
        bp_flush    = 1'b0;
        bp_target   = '0;
    endtask

    // Advance to just after the next rising edge; inputs are then driven and checked at +4.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"idle",        5'b00000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'b00000, 6'b000000, 0, 32'h0};
        vecs[1]  = '{"req_mem",     5'b00001, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'b11111, 6'b000000, 0, 32'h0};
        vecs[2]  = '{"req_disp",    5'b00100, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'b11100, 6'b000000, 0, 32'h0};
        vecs[3]  = '{"req_buf",     5'b10000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'b10000, 6'b000000, 0, 32'h0};
        vecs[4]  = '{"req_mix",     5'b01010, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'b11110, 6'b000000, 0, 32'h0};
        vecs[5]  = '{"excp",        5'b00001, 1, 0, 0, 32'h1C008000, 32'h0, 32'h0, 5'b00000, 6'b111111, 1, 32'h1C008000};
        vecs[6]  = '{"bp_exe_stall",5'b00010, 0, 0, 1, 32'h0, 32'h0, 32'h1C000040, 5'b11110, 6'b000000, 0, 32'h0};
        vecs[7]  = '{"bp_taken",    5'b00000, 0, 0, 1, 32'h0, 32'h0, 32'h1C000040, 5'b00000, 6'b111000, 1, 32'h1C000040};
        vecs[8]  = '{"bp_disp_stall",5'b00100,0, 0, 1, 32'h0, 32'h0, 32'h1C000080, 5'b11100, 6'b111000, 1, 32'h1C000080};
        vecs[9]  = '{"ertn_bp",     5'b00000, 0, 1, 1, 32'h0, 32'h1C000200, 32'h1C000040, 5'b00000, 6'b111111, 1, 32'h1C000200};
        vecs[10] = '{"excp_ertn",   5'b00000, 1, 1, 0, 32'h1C008000, 32'h1C000200, 32'h0, 5'b00000, 6'b111111, 1, 32'h1C008000};
        vecs[11] = '{"ertn_allreq", 5'b11111, 0, 1, 0, 32'h0, 32'h1C000300, 32'h0, 5'b00000, 6'b111111, 1, 32'h1C000300};

        // Reset state
        do_reset();
        #3;
        check("rst_pause", 32'(pause), 32'h0);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_redir", 32'(redirect_valid), 32'h0);
        check("rst_newpc", new_pc, 32'h0);
        check("rst_in_idle", 32'(in_idle), 32'h0);
        check("rst_stall_cnt", stall_cycles, 32'h0);
        check("rst_flush_cnt", flush_count, 32'h0);

        // Combinational vectors, each from RUN with no hold active
        for (int i = 0; i < 12; i++) begin
            cyc();
            pause_req   = vecs[i].req;
            excp_commit = vecs[i].excp;
            ertn_commit = vecs[i].ertn;
            bp_flush    = vecs[i].bp;
            excp_target = vecs[i].tgt_excp;
            era         = vecs[i].tgt_era;
            bp_target   = vecs[i].tgt_bp;
            #4;
            check({vecs[i].name, "_pause"}, 32'(pause), 32'(vecs[i].exp_pause));
            check({vecs[i].name, "_flush"}, 32'(flush), 32'(vecs[i].exp_flush));
            check({vecs[i].name, "_redir"}, 32'(redirect_valid), 32'(vecs[i].exp_redir));
            check({vecs[i].name, "_newpc"}, new_pc, vecs[i].exp_pc);
            cyc();
            clear_inputs();
            repeat (3) cyc();
        end

        // Stall counter increments each paused cycle
        do_reset();
        pause_req = 5'b00001;
        repeat (5) cyc();
        check("stall_cnt_5", stall_cycles, 32'd5);
        clear_inputs();
        cyc();
        cyc();
        check("stall_cnt_hold", stall_cycles, 32'd5);

        // Exception then two-cycle buffer hold
        do_reset();
        excp_commit = 1'b1;
        excp_target = 32'h1C008000;
        pause_req   = 5'b00001;
        #4;
        check("hold_excp_pause", 32'(pause), 32'h0);
        check("hold_excp_flush", 32'(flush), 32'h3F);
        cyc();
        clear_inputs();
        #4;
        check("hold_c1", 32'(pause), 32'b10000);
        cyc();
        #4;
        check("hold_c2", 32'(pause), 32'b10000);
        cyc();
        #4;
        check("hold_done", 32'(pause), 32'b00000);
        check("hold_flush_cnt", flush_count, 32'd1);

        // Redirect during hold reloads the counter
        do_reset();
        bp_flush  = 1'b1;
        bp_target = 32'h1C000040;
        cyc();
        #4;
        check("reload_bp2_redir", 32'(redirect_valid), 32'h1);
        cyc();
        clear_inputs();
        #4;
        check("reload_c1", 32'(pause), 32'b10000);
        cyc();
        #4;
        check("reload_c2", 32'(pause), 32'b10000);
        cyc();
        #4;
        check("reload_done", 32'(pause), 32'b00000);
        check("reload_flush_cnt", flush_count, 32'd2);

        // ertn + bp in one cycle counts one redirect
        do_reset();
        ertn_commit = 1'b1;
        era         = 32'h1C000200;
        bp_flush    = 1'b1;
        bp_target   = 32'h1C000040;
        cyc();
        clear_inputs();
        #4;
        check("ertn_bp_cnt", flush_count, 32'd1);

        // IDLE entry, wait and interrupt wake-up
        do_reset();
        idle_commit = 1'b1;
        idle_pc     = 32'h1C000100;
        #4;
        check("idle_newpc", new_pc, 32'h1C000104);
        check("idle_flush", 32'(flush), 32'h3E);
        check("idle_redir", 32'(redirect_valid), 32'h1);
        cyc();
        clear_inputs();
        for (int c = 0; c < 10; c++) begin
            #4;
            check($sformatf("idle_wait%0d_pause", c), 32'(pause), 32'b11100);
            check($sformatf("idle_wait%0d_in", c), 32'(in_idle), 32'h1);
            cyc();
        end
        int_pending = 1'b1;
        #4;
        check("idle_wake_pause", 32'(pause), 32'h0);
        cyc();
        int_pending = 1'b0;
        #4;
        check("idle_exit", 32'(in_idle), 32'h0);

        // Exception while in IDLE returns to RUN
        do_reset();
        idle_commit = 1'b1;
        idle_pc     = 32'h1C000100;
        cyc();
        clear_inputs();
        repeat (3) cyc();
        excp_commit = 1'b1;
        excp_target = 32'h1C008000;
        #4;
        check("idle_excp_newpc", new_pc, 32'h1C008000);
        check("idle_excp_pause", 32'(pause), 32'h0);
        cyc();
        clear_inputs();
        #4;
        check("idle_excp_run", 32'(in_idle), 32'h0);

        // idle_commit with int_pending: enter IDLE, exit next cycle
        do_reset();
        idle_commit = 1'b1;
        int_pending = 1'b1;
        cyc();
        idle_commit = 1'b0;
        #4;
        check("idle_int_enter", 32'(in_idle), 32'h1);
        cyc();
        #4;
        check("idle_int_exit", 32'(in_idle), 32'h0);
        clear_inputs();

        // Asynchronous reset in IDLE
        do_reset();
        idle_commit = 1'b1;
        cyc();
        clear_inputs();
        repeat (2) cyc();
        #2 rst = 1'b1;
        #1;
        check("arst_idle_in", 32'(in_idle), 32'h0);
        check("arst_idle_pause", 32'(pause), 32'h0);
        check("arst_idle_stall", stall_cycles, 32'h0);
        check("arst_idle_fcnt", flush_count, 32'h0);
        cyc();
        rst = 1'b0;

        // Asynchronous reset during hold
        cyc();
        excp_commit = 1'b1;
        cyc();
        clear_inputs();
        #2 rst = 1'b1;
        #1;
        check("arst_hold_pause", 32'(pause), 32'h0);
        check("arst_hold_fcnt", flush_count, 32'h0);
        cyc();
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
